// File: rtl/match_sequencer_if.sv
// Match sequencer control/status bundle.
// The game controller (master) drives frame timing, button and hit/shield
// strobes; the sequencer (slave) returns match state, hit points, round
// tallies and timers.
interface match_sequencer_if;
    logic       frame_tick;
    logic       select;
    logic       player_hit;
    logic       enemy_hit;
    logic       player_shield;
    logic       enemy_shield;
    logic [2:0] state;
    logic       is_gaming;
    logic       entity_rst;
    logic [1:0] player_hp;
    logic [1:0] enemy_hp;
    logic [1:0] player_rounds;
    logic [1:0] enemy_rounds;
    logic [7:0] countdown;
    logic       player_invuln;
    logic       enemy_invuln;

    modport master (
        output frame_tick, select, player_hit, enemy_hit, player_shield, enemy_shield,
        input  state, is_gaming, entity_rst, player_hp, enemy_hp,
               player_rounds, enemy_rounds, countdown, player_invuln, enemy_invuln
    );

    modport slave (
        input  frame_tick, select, player_hit, enemy_hit, player_shield, enemy_shield,
        output state, is_gaming, entity_rst, player_hp, enemy_hp,
               player_rounds, enemy_rounds, countdown, player_invuln, enemy_invuln
    );
endinterface

// File: rtl/match_sequencer.sv
// Match sequencer: walks a two-sided match through idle, countdown, play,
// round-end pause and win/lose screens, tracking hit points, invulnerability
// windows and round wins. All outputs are registered except is_gaming.
module match_sequencer #(
    parameter int HP_MAX           = 3,
    parameter int ROUNDS_TO_WIN    = 2,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int INVULN_FRAMES    = 30,
    parameter int ROUNDEND_FRAMES  = 60
) (
    input logic              clk,
    input logic              rst_n,
    match_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COUNTDOWN  = 3'd1,
        ST_PLAY       = 3'd2,
        ST_ROUND_END  = 3'd3,
        ST_MATCH_WIN  = 3'd4,
        ST_MATCH_LOSE = 3'd5
    } state_t;

    localparam logic [1:0] HP_INIT  = 2'(HP_MAX);
    localparam logic [1:0] WIN_CNT  = 2'(ROUNDS_TO_WIN);
    localparam logic [7:0] CD_INIT  = 8'(COUNTDOWN_FRAMES);
    localparam logic [7:0] INV_INIT = 8'(INVULN_FRAMES);
    localparam logic [7:0] RE_INIT  = 8'(ROUNDEND_FRAMES);

    // Round tally increment that sticks at the 2-bit ceiling.
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

    state_t     state_r;
    logic       select_q_r;
    logic       entity_rst_r;
    logic [1:0] player_hp_r;
    logic [1:0] enemy_hp_r;
    logic [1:0] player_rounds_r;
    logic [1:0] enemy_rounds_r;
    logic [7:0] countdown_r;
    logic [7:0] rend_timer_r;
    logic [7:0] p_inv_cnt_r;
    logic [7:0] e_inv_cnt_r;
    logic       player_invuln_r;
    logic       enemy_invuln_r;

    logic       sel_edge_s;
    logic       p_hit_ok_s;
    logic       e_hit_ok_s;
    logic       rend_next_cd_s;
    logic [7:0] p_inv_nxt_s;
    logic [7:0] e_inv_nxt_s;

    // Hit acceptance, select edge and round-end-to-countdown decode.
    always_comb begin
        sel_edge_s     = bus.select & ~select_q_r;
        p_hit_ok_s     = (state_r == ST_PLAY) && bus.player_hit && !bus.player_shield &&
                         (p_inv_cnt_r == 8'd0) && (player_hp_r != 2'd0);
        e_hit_ok_s     = (state_r == ST_PLAY) && bus.enemy_hit && !bus.enemy_shield &&
                         (e_inv_cnt_r == 8'd0) && (enemy_hp_r != 2'd0);
        rend_next_cd_s = (state_r == ST_ROUND_END) && (rend_timer_r == 8'd0) &&
                         (player_rounds_r != WIN_CNT) && (enemy_rounds_r != WIN_CNT);
    end

    // Next value of both invulnerability counters: cleared on a new round,
    // loaded on an accepted hit, otherwise counting down per frame in any state.
    always_comb begin
        p_inv_nxt_s = p_inv_cnt_r;
        e_inv_nxt_s = e_inv_cnt_r;
        if (rend_next_cd_s) begin
            p_inv_nxt_s = 8'd0;
        end else if (p_hit_ok_s) begin
            p_inv_nxt_s = INV_INIT;
        end else if (bus.frame_tick && (p_inv_cnt_r != 8'd0)) begin
            p_inv_nxt_s = p_inv_cnt_r - 8'd1;
        end else begin
            p_inv_nxt_s = p_inv_cnt_r;
        end
        if (rend_next_cd_s) begin
            e_inv_nxt_s = 8'd0;
        end else if (e_hit_ok_s) begin
            e_inv_nxt_s = INV_INIT;
        end else if (bus.frame_tick && (e_inv_cnt_r != 8'd0)) begin
            e_inv_nxt_s = e_inv_cnt_r - 8'd1;
        end else begin
            e_inv_nxt_s = e_inv_cnt_r;
        end
    end

    // Match FSM with all of its registered outputs and timers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            select_q_r      <= 1'b0;
            entity_rst_r    <= 1'b0;
            player_hp_r     <= HP_INIT;
            enemy_hp_r      <= HP_INIT;
            player_rounds_r <= 2'd0;
            enemy_rounds_r  <= 2'd0;
            countdown_r     <= 8'd0;
            rend_timer_r    <= 8'd0;
            p_inv_cnt_r     <= 8'd0;
            e_inv_cnt_r     <= 8'd0;
            player_invuln_r <= 1'b0;
            enemy_invuln_r  <= 1'b0;
        end else begin
            select_q_r      <= bus.select;
            entity_rst_r    <= 1'b0;
            p_inv_cnt_r     <= p_inv_nxt_s;
            e_inv_cnt_r     <= e_inv_nxt_s;
            player_invuln_r <= (p_inv_nxt_s != 8'd0);
            enemy_invuln_r  <= (e_inv_nxt_s != 8'd0);
            case (state_r)
                ST_IDLE: begin
                    if (sel_edge_s) begin
                        state_r         <= ST_COUNTDOWN;
                        entity_rst_r    <= 1'b1;
                        player_hp_r     <= HP_INIT;
                        enemy_hp_r      <= HP_INIT;
                        player_rounds_r <= 2'd0;
                        enemy_rounds_r  <= 2'd0;
                        countdown_r     <= CD_INIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_COUNTDOWN: begin
                    if (countdown_r == 8'd0) begin
                        state_r <= ST_PLAY;
                    end else if (bus.frame_tick) begin
                        countdown_r <= countdown_r - 8'd1;
                    end else begin
                        countdown_r <= countdown_r;
                    end
                end
                ST_PLAY: begin
                    // An accepted hit implies hp is non-zero, so no underflow.
                    if (p_hit_ok_s) begin
                        player_hp_r <= player_hp_r - 2'd1;
                    end else begin
                        player_hp_r <= player_hp_r;
                    end
                    if (e_hit_ok_s) begin
                        enemy_hp_r <= enemy_hp_r - 2'd1;
                    end else begin
                        enemy_hp_r <= enemy_hp_r;
                    end
                    if ((player_hp_r == 2'd0) || (enemy_hp_r == 2'd0)) begin
                        state_r      <= ST_ROUND_END;
                        rend_timer_r <= RE_INIT;
                        // Both sides down together is a draw: no tally change.
                        if ((enemy_hp_r == 2'd0) && (player_hp_r != 2'd0)) begin
                            player_rounds_r <= sat_inc2(player_rounds_r);
                        end else if ((player_hp_r == 2'd0) && (enemy_hp_r != 2'd0)) begin
                            enemy_rounds_r <= sat_inc2(enemy_rounds_r);
                        end else begin
                            player_rounds_r <= player_rounds_r;
                        end
                    end else begin
                        state_r <= ST_PLAY;
                    end
                end
                ST_ROUND_END: begin
                    if (rend_timer_r == 8'd0) begin
                        if (player_rounds_r == WIN_CNT) begin
                            state_r <= ST_MATCH_WIN;
                        end else if (enemy_rounds_r == WIN_CNT) begin
                            state_r <= ST_MATCH_LOSE;
                        end else begin
                            state_r      <= ST_COUNTDOWN;
                            entity_rst_r <= 1'b1;
                            player_hp_r  <= HP_INIT;
                            enemy_hp_r   <= HP_INIT;
                            countdown_r  <= CD_INIT;
                        end
                    end else if (bus.frame_tick) begin
                        rend_timer_r <= rend_timer_r - 8'd1;
                    end else begin
                        rend_timer_r <= rend_timer_r;
                    end
                end
                ST_MATCH_WIN, ST_MATCH_LOSE: begin
                    if (sel_edge_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    // Unreachable encodings recover to a quiet idle.
                    state_r      <= ST_IDLE;
                    countdown_r  <= 8'd0;
                    rend_timer_r <= 8'd0;
                end
            endcase
        end
    end

    assign bus.state         = state_r;
    assign bus.is_gaming     = (state_r == ST_PLAY);
    assign bus.entity_rst    = entity_rst_r;
    assign bus.player_hp     = player_hp_r;
    assign bus.enemy_hp      = enemy_hp_r;
    assign bus.player_rounds = player_rounds_r;
    assign bus.enemy_rounds  = enemy_rounds_r;
    assign bus.countdown     = countdown_r;
    assign bus.player_invuln = player_invuln_r;
    assign bus.enemy_invuln  = enemy_invuln_r;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed scoreboard bench for match_sequencer: each scenario pushes the
// values it expects as it drives stimulus, then pops and compares once the
// sequencer has had the clock edge to respond.
module tb_match_sequencer;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    exp_t e;

    match_sequencer_if bus ();

    match_sequencer #(
        .HP_MAX          (3),
        .ROUNDS_TO_WIN   (2),
        .COUNTDOWN_FRAMES(3),
        .INVULN_FRAMES   (2),
        .ROUNDEND_FRAMES (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
    endtask

    task automatic hit(input logic p, input logic en);
        bus.player_hit = p;
        bus.enemy_hit  = en;
        cyc();
        bus.player_hit = 1'b0;
        bus.enemy_hit  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.frame_tick = 1'b0; bus.select = 1'b0;
        bus.player_hit = 1'b0; bus.enemy_hit = 1'b0;
        bus.player_shield = 1'b0; bus.enemy_shield = 1'b0;
        repeat (2) cyc();
        exp_q.push_back('{"rst_state", 32'd0});
        exp_q.push_back('{"rst_php", 32'd3});
        exp_q.push_back('{"rst_ehp", 32'd3});
        exp_q.push_back('{"rst_countdown", 32'd0});
        exp_q.push_back('{"rst_entity_rst", 32'd0});
        rst_n = 1'b1;
        cyc();
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.player_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.player_hp, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.enemy_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.enemy_hp, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.countdown) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.countdown, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.entity_rst) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.entity_rst, e.val); end
    endtask

    task automatic test_start();
        int pulses;
        pulses = 0;
        exp_q.push_back('{"start_pulses", 32'd1});
        exp_q.push_back('{"start_state", 32'd1});
        bus.select = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            pulses += int'(bus.entity_rst);
        end
        bus.select = 1'b0;
        e = exp_q.pop_front(); n_checks++;
        if (32'(pulses) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, pulses, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
        for (int c = 3; c >= 0; c--) begin
            exp_q.push_back('{"start_countdown", 32'(c)});
            if (c != 3) frame();
            e = exp_q.pop_front(); n_checks++;
            if (32'(bus.countdown) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.countdown, e.val); end
        end
        exp_q.push_back('{"start_still_cd", 32'd1});
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
        exp_q.push_back('{"start_play", 32'd2});
        exp_q.push_back('{"start_is_gaming", 32'd1});
        cyc();
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.is_gaming) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.is_gaming, e.val); end
    endtask

    task automatic test_invuln();
        exp_q.push_back('{"inv_ehp_once", 32'd2});
        exp_q.push_back('{"inv_active", 32'd1});
        bus.enemy_hit = 1'b1;
        repeat (5) cyc();
        bus.enemy_hit = 1'b0;
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.enemy_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.enemy_hp, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.enemy_invuln) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.enemy_invuln, e.val); end
        exp_q.push_back('{"inv_after_1tick", 32'd1});
        frame();
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.enemy_invuln) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.enemy_invuln, e.val); end
        exp_q.push_back('{"inv_after_2tick", 32'd0});
        frame();
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.enemy_invuln) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.enemy_invuln, e.val); end
        exp_q.push_back('{"inv_later_hit", 32'd1});
        hit(1'b0, 1'b1);
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.enemy_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.enemy_hp, e.val); end
        repeat (2) frame();
    endtask

    task automatic test_shield();
        exp_q.push_back('{"shield_php", 32'd3});
        exp_q.push_back('{"shield_pinv", 32'd0});
        bus.player_shield = 1'b1;
        hit(1'b1, 1'b0);
        bus.player_shield = 1'b0;
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.player_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.player_hp, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.player_invuln) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.player_invuln, e.val); end
    endtask

    task automatic test_draw();
        hit(1'b1, 1'b0); repeat (2) frame();
        hit(1'b1, 1'b0); repeat (2) frame();
        exp_q.push_back('{"draw_php", 32'd0});
        exp_q.push_back('{"draw_ehp", 32'd0});
        hit(1'b1, 1'b1);
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.player_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.player_hp, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.enemy_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.enemy_hp, e.val); end
        exp_q.push_back('{"draw_round_end", 32'd3});
        exp_q.push_back('{"draw_prounds", 32'd0});
        exp_q.push_back('{"draw_erounds", 32'd0});
        cyc();
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.player_rounds) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.player_rounds, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.enemy_rounds) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.enemy_rounds, e.val); end
        exp_q.push_back('{"draw_to_cd", 32'd1});
        exp_q.push_back('{"draw_php_reload", 32'd3});
        exp_q.push_back('{"draw_ehp_reload", 32'd3});
        exp_q.push_back('{"draw_entity_rst", 32'd1});
        repeat (2) frame();
        cyc();
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.player_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.player_hp, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.enemy_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.enemy_hp, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.entity_rst) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.entity_rst, e.val); end
    endtask

    // Plays one round from COUNTDOWN entry in which the player knocks the enemy out.
    task automatic win_round(input int exp_rounds, input int exp_final);
        exp_q.push_back('{"win_play", 32'd2});
        repeat (3) frame();
        cyc();
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
        for (int k = 0; k < 3; k++) begin
            hit(1'b0, 1'b1);
            if (k < 2) repeat (2) frame();
        end
        exp_q.push_back('{"win_round_end", 32'd3});
        exp_q.push_back('{"win_prounds", 32'(exp_rounds)});
        cyc();
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.player_rounds) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.player_rounds, e.val); end
        exp_q.push_back('{"win_next_state", 32'(exp_final)});
        exp_q.push_back('{"win_entity_rst", (exp_final == 1) ? 32'd1 : 32'd0});
        repeat (2) frame();
        cyc();
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.entity_rst) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.entity_rst, e.val); end
    endtask

    task automatic test_match();
        win_round(1, 1);
        win_round(2, 4);
        exp_q.push_back('{"match_hold_state", 32'd4});
        exp_q.push_back('{"match_hold_ehp", 32'd0});
        repeat (3) cyc();
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.enemy_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.enemy_hp, e.val); end
        exp_q.push_back('{"match_to_idle", 32'd0});
        exp_q.push_back('{"match_rounds_kept", 32'd2});
        bus.select = 1'b1;
        cyc();
        bus.select = 1'b0;
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.player_rounds) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.player_rounds, e.val); end
        cyc();
        exp_q.push_back('{"rematch_state", 32'd1});
        exp_q.push_back('{"rematch_prounds", 32'd0});
        exp_q.push_back('{"rematch_ehp", 32'd3});
        bus.select = 1'b1;
        cyc();
        bus.select = 1'b0;
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.player_rounds) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.player_rounds, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.enemy_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.enemy_hp, e.val); end
    endtask

    task automatic test_reset_mid_play();
        int pulses;
        repeat (3) frame();
        cyc();
        hit(1'b1, 1'b0); repeat (2) frame();
        hit(1'b1, 1'b0); repeat (2) frame();
        exp_q.push_back('{"mid_php", 32'd1});
        exp_q.push_back('{"mid_ehp", 32'd2});
        hit(1'b0, 1'b1);
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.player_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.player_hp, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.enemy_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.enemy_hp, e.val); end
        exp_q.push_back('{"arst_state", 32'd0});
        exp_q.push_back('{"arst_php", 32'd3});
        exp_q.push_back('{"arst_ehp", 32'd3});
        exp_q.push_back('{"arst_is_gaming", 32'd0});
        #2;
        rst_n = 1'b0;
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.player_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.player_hp, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.enemy_hp) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.enemy_hp, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.is_gaming) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.is_gaming, e.val); end
        exp_q.push_back('{"arst_no_pulse", 32'd0});
        exp_q.push_back('{"arst_idle_after", 32'd0});
        pulses = int'(bus.entity_rst);
        repeat (2) begin cyc(); pulses += int'(bus.entity_rst); end
        rst_n = 1'b1;
        repeat (2) begin cyc(); pulses += int'(bus.entity_rst); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(pulses) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, pulses, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(bus.state) !== e.val) begin n_fail++; $display("FAIL %s: got %0d want %0d", e.name, bus.state, e.val); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_start();
        test_invuln();
        test_shield();
        test_draw();
        test_match();
        test_reset_mid_play();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 Parameter HP_MAX, default 3: hit points loaded per round, legal range 1..3.
REQ-002 Parameter ROUNDS_TO_WIN, default 2: round wins that end the match, legal range 1..3.
REQ-003 Parameter COUNTDOWN_FRAMES, default 180: pre-round countdown length in frames, legal range 1..255.
REQ-004 Parameter INVULN_FRAMES, default 30: post-hit invulnerability length in frames, legal range 1..255.
REQ-005 Parameter ROUNDEND_FRAMES, default 60: round-end pause length in frames, legal range 1..255.
REQ-006 clk  in  1  system clock.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 frame_tick  in  1  one-cycle pulse per video frame.
REQ-009 select  in  1  start/confirm button, level, synchronous to clk.
REQ-010 player_hit, enemy_hit  in  1 each  bullet-hit strobes from the bullet datapath.
REQ-011 player_shield, enemy_shield  in  1 each  shield active.
REQ-012 state  out  3  0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 ROUND_END, 4 MATCH_WIN, 5 MATCH_LOSE.
REQ-013 is_gaming  out  1  high only in PLAY; enables movement and bullet datapath.
REQ-014 entity_rst  out  1  one-cycle pulse that re-initialises positions and bullets.
REQ-015 player_hp, enemy_hp  out  2 each  current hit points.
REQ-016 player_rounds, enemy_rounds  out  2 each  rounds won this match.
REQ-017 countdown  out  8  remaining countdown frames; 0 outside COUNTDOWN.
REQ-018 player_invuln, enemy_invuln  out  1 each  invulnerability window active.

Function
REQ-019 The block SHALL detect a select rising edge as select=1 while the previous-cycle registered select=0; all select-driven transitions use only this edge.
REQ-020 IDLE: on a select edge the block SHALL enter COUNTDOWN next cycle, pulse entity_rst in that same cycle, load both hp with HP_MAX, and clear both round counters.
REQ-021 COUNTDOWN: the countdown counter SHALL be COUNTDOWN_FRAMES on entry and decrement by 1 per frame_tick; when it equals 0 the block SHALL enter PLAY on the next clock.
REQ-022 PLAY: a hit SHALL be accepted only when state is PLAY, the matching hit strobe is 1, the matching shield is 0, the matching invuln is 0, and the matching hp is non-zero.
REQ-023 An accepted hit SHALL decrement hp by 1 at the next edge and load that side's invuln counter with INVULN_FRAMES in the same edge.
REQ-024 Each invuln counter SHALL decrement per frame_tick while non-zero, in every state; invuln output is (counter != 0).
REQ-025 Player and enemy hits in the same cycle SHALL be processed independently.
REQ-026 PLAY with either registered hp == 0 SHALL enter ROUND_END next cycle. If only enemy_hp is 0, player_rounds increments. If only player_hp is 0, enemy_rounds increments. If both are 0, this is a draw and neither counter changes.
REQ-027 ROUND_END: the timer SHALL load ROUNDEND_FRAMES on entry and decrement per frame_tick. At 0, the next state is selected in priority order:
- player_rounds == ROUNDS_TO_WIN -> MATCH_WIN.
- else enemy_rounds == ROUNDS_TO_WIN -> MATCH_LOSE.
- else COUNTDOWN, with entity_rst pulse, hp reload to HP_MAX, and both invuln counters cleared.
REQ-028 MATCH_WIN / MATCH_LOSE: on a select edge the block SHALL enter IDLE next cycle; hp and round outputs hold until then.
REQ-029 Select edges in COUNTDOWN, PLAY and ROUND_END SHALL be ignored.
REQ-030 Round counters SHALL saturate at 3; hp SHALL never underflow below 0.
REQ-031 All outputs SHALL be registered except is_gaming, which is decoded from the state register.
REQ-032 Undefined state encodings 6 and 7 SHALL transition to IDLE on the next clock.

Reset
REQ-033 rst_n low SHALL asynchronously force the following, regardless of the current operation:
- state IDLE, entity_rst 0.
- hp HP_MAX, rounds 0.
- countdown 0, all timers 0, invuln 0, registered select 0.

Verification
REQ-034 The bench SHALL cover the following directed scenarios, all with COUNTDOWN_FRAMES=3, INVULN_FRAMES=2, ROUNDEND_FRAMES=2, ROUNDS_TO_WIN=2, HP_MAX=3:
- Start: select held high 10 cycles from IDLE -> exactly one entity_rst pulse; COUNTDOWN with countdown 3,2,1,0 on successive ticks; PLAY one clock after countdown reaches 0.
- Invuln: enemy_hit high 5 consecutive cycles in PLAY -> enemy_hp 3->2 once; enemy_invuln 1 until 2 frame_ticks elapse; a later hit -> 1.
- Shield: player_hit with player_shield=1 -> player_hp unchanged and player_invuln stays 0.
- Draw: both hp=1, both hits in the same cycle -> both hp 0; ROUND_END with rounds unchanged; after 2 ticks -> COUNTDOWN, hp 3/3, entity_rst pulse.
- Match: player wins 2 rounds -> MATCH_WIN, player_rounds=2; a select edge -> IDLE; next select -> rounds 0.
- Reset: rst_n asserted mid-PLAY with hp 1/2 -> immediate IDLE, hp 3/3, is_gaming 0, no entity_rst pulse.
